// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: word width, Group 1 operate bit positions,
// and the state encoding of the operate sequencer.
package pdp8_pkg;

  localparam int WORD_W = 12;

  // Bit positions within opr (IR[4:11]).
  localparam int OPR_CLA = 7;
  localparam int OPR_CLL = 6;
  localparam int OPR_CMA = 5;
  localparam int OPR_CML = 4;
  localparam int OPR_RAR = 3;
  localparam int OPR_RAL = 2;
  localparam int OPR_RT  = 1;  // doubles the rotate, or BSW when no RAR/RAL
  localparam int OPR_IAC = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_CMP  = 3'd2,
    ST_INC  = 3'd3,
    ST_ROT1 = 3'd4,
    ST_ROT2 = 3'd5,
    ST_DONE = 3'd6
  } opr1_state_e;

endpackage

// File: rtl/opr1_rotate.sv
// Combinational rotator over the {link,ac} ring. Used for both the first
// and the second rotate step of the operate sequence.
module opr1_rotate #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH:0] lac_i,  // {link, ac}
  input  logic           rar_i,
  input  logic           ral_i,
  input  logic           bsw_i,
  output logic [WIDTH:0] lac_o
);

  localparam int HALF = WIDTH / 2;

  // RAR and RAL together cancel; BSW applies only when neither is set.
  always_comb begin
    lac_o = lac_i;
    if (rar_i && !ral_i)
      lac_o = {lac_i[0], lac_i[WIDTH:1]};
    else if (ral_i && !rar_i)
      lac_o = {lac_i[WIDTH-1:0], lac_i[WIDTH]};
    else if (bsw_i && !rar_i && !ral_i)
      lac_o = {lac_i[WIDTH], lac_i[HALF-1:0], lac_i[WIDTH-1:HALF]};
  end

endmodule

// File: rtl/opr1_accumulator.sv
// PDP-8 Group 1 operate unit: runs CLR, CMP, INC, ROT1, ROT2 as a fixed
// sequence on the AC/link pair, then pulses done for one cycle.
module opr1_accumulator
  import pdp8_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       opr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] ac,
  output logic             link,
  output logic             busy,
  output logic             done
);

  opr1_state_e      state_q;
  logic [7:0]       opr_q;
  logic [WIDTH-1:0] ac_q;
  logic             link_q;
  logic [WIDTH:0]   rot_res;
  logic             rot_bsw;
  logic             rot_twice;

  // BSW is a single swap; only RTR/RTL get a second step.
  assign rot_bsw   = (state_q == ST_ROT1) && opr_q[OPR_RT];
  assign rot_twice = opr_q[OPR_RT] && (opr_q[OPR_RAR] ^ opr_q[OPR_RAL]);

  opr1_rotate #(.WIDTH(WIDTH)) u_rot (
    .lac_i ({link_q, ac_q}),
    .rar_i (opr_q[OPR_RAR]),
    .ral_i (opr_q[OPR_RAL]),
    .bsw_i (rot_bsw),
    .lac_o (rot_res)
  );

  // Sequencer plus the opr capture and AC/link registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      opr_q   <= '0;
      ac_q    <= '0;
      link_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            opr_q   <= opr;
            state_q <= ST_CLR;
          end else if (load) begin
            ac_q <= din;
          end
        end
        ST_CLR: begin
          if (opr_q[OPR_CLA]) ac_q   <= '0;
          if (opr_q[OPR_CLL]) link_q <= 1'b0;
          state_q <= ST_CMP;
        end
        ST_CMP: begin
          if (opr_q[OPR_CMA]) ac_q   <= ~ac_q;
          if (opr_q[OPR_CML]) link_q <= ~link_q;
          state_q <= ST_INC;
        end
        ST_INC: begin
          if (opr_q[OPR_IAC]) {link_q, ac_q} <= {link_q, ac_q} + {{WIDTH{1'b0}}, 1'b1};
          state_q <= ST_ROT1;
        end
        ST_ROT1: begin
          {link_q, ac_q} <= rot_res;
          state_q        <= ST_ROT2;
        end
        ST_ROT2: begin
          if (rot_twice) {link_q, ac_q} <= rot_res;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ac   = ac_q;
  assign link = link_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_opr1_accumulator.sv
// Directed plus randomized checks of the Group 1 operate unit against an
// arithmetic reference of the microinstruction semantics.
module tb_opr1_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  opr = '0;
  logic [11:0] din = '0;
  logic [11:0] ac;
  logic        link, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] m_ac = '0;
  logic        m_link = 1'b0;

  opr1_accumulator #(.WIDTH(12)) dut (
    .clk(clk), .reset(reset), .start(start), .opr(opr), .load(load),
    .din(din), .ac(ac), .link(link), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic over the 13-bit value link*4096 + ac.
  function automatic logic [12:0] ref_opr(input logic [7:0] o, input logic l, input logic [11:0] a);
    int acc, lk, v, n;
    acc = int'(a);
    lk  = int'(l);
    if (o[7]) acc = 0;
    if (o[6]) lk = 0;
    if (o[5]) acc = 4095 - acc;
    if (o[4]) lk = 1 - lk;
    v = lk * 4096 + acc;
    if (o[0]) v = (v + 1) % 8192;
    n = o[1] ? 2 : 1;
    if (o[3] && !o[2]) begin
      for (int k = 0; k < n; k++) v = v / 2 + (v % 2) * 4096;
    end else if (o[2] && !o[3]) begin
      for (int k = 0; k < n; k++) v = (v * 2) % 8192 + v / 4096;
    end else if (o[1] && !o[3] && !o[2]) begin
      acc = v % 4096;
      v = (v / 4096) * 4096 + (acc % 64) * 64 + acc / 64;
    end
    return 13'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0o required %0o", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [11:0] d);
    load = 1'b1;
    din  = d;
    tick();
    load = 1'b0;
    m_ac = d;
    chk("load_ac", 32'(ac), 32'(d));
  endtask

  // Issue one operate; optionally with a simultaneous load and with
  // start/load pokes while busy (sampled at E3).
  task automatic do_op(input logic [7:0] o, input bit with_load, input logic [11:0] ld_val,
                       input bit poke, input string tag);
    logic [12:0] e;
    int lat, ndone;
    e = ref_opr(o, m_link, m_ac);
    start = 1'b1; opr = o; load = with_load; din = ld_val;
    tick();
    start = 1'b0; load = 1'b0; opr = 8'($urandom);
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 10) begin
      if (poke && lat == 2) begin
        start = 1'b1; load = 1'b1; din = 12'($urandom);
      end
      tick();
      start = 1'b0; load = 1'b0;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_ac"}, 32'(ac), 32'(e[11:0]));
    chk({tag, "_link"}, 32'(link), 32'(e[12]));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    if (poke) begin
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (done) ndone++;
      end
      chk({tag, "_extra_done"}, 32'(ndone), 32'd0);
    end
    m_ac = e[11:0];
    m_link = e[12];
  endtask

  initial begin
    int ndone;
    logic [7:0] o;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ac", 32'(ac), 32'd0);
    chk("rst_link", 32'(link), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // IAC wraps 7777 to 0000 and flips link.
    do_load(12'o7777);
    do_op(8'b0000_0001, 1'b0, '0, 1'b0, "iac_wrap");
    chk("iac_wrap_ac_const", 32'(ac), 32'o0000);
    chk("iac_wrap_link_const", 32'(link), 32'd1);

    do_load(12'o0123);
    do_op(8'b1110_0000, 1'b0, '0, 1'b0, "cla_cll_cma");
    chk("cla_cll_cma_const", 32'(ac), 32'o7777);
    chk("cla_cll_cma_link_const", 32'(link), 32'd0);

    do_load(12'o0001);
    do_op(8'b0000_1000, 1'b0, '0, 1'b0, "rar");
    chk("rar_ac_const", 32'(ac), 32'o0000);
    chk("rar_link_const", 32'(link), 32'd1);
    do_op(8'b0000_1010, 1'b0, '0, 1'b0, "rtr");
    chk("rtr_ac_const", 32'(ac), 32'o2000);
    chk("rtr_link_const", 32'(link), 32'd0);

    do_load(12'o1234);
    do_op(8'b0000_0010, 1'b0, '0, 1'b0, "bsw");
    chk("bsw_ac_const", 32'(ac), 32'o3412);
    chk("bsw_link_const", 32'(link), 32'd0);

    // start wins over load; pokes while busy are ignored.
    do_load(12'o0000);
    do_op(8'b0000_0001, 1'b1, 12'o5555, 1'b1, "start_load");
    chk("start_load_ac_const", 32'(ac), 32'o0001);

    // Reset in ROT1 discards the sequence.
    do_load(12'o1234);
    start = 1'b1; opr = 8'b1010_0101;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ac", 32'(ac), 32'd0);
    chk("midrst_link", 32'(link), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    m_ac = '0; m_link = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);

    // Random operate mix against the reference.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) do_load(12'($urandom));
      o = 8'($urandom);
      do_op(o, 1'b0, '0, (i % 8) == 3, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
